imem_responder: RTL
===================

Name: imem_responder

Overview:
- Responder end of the instruction-fetch interface. It consumes the fetch stage's `ice`/`iaddr` request and returns a 32-bit instruction word from an internal word-addressed instruction RAM.
- It can model a slow memory: a wait-state counter raises a stall request toward the stall controller until the word is ready.
- A side load port lets the testbench or boot logic write program words.

Parameters:
- ADDR_W, 12, word-index width; RAM depth = 2^ADDR_W words.
- WAIT_CYCLES, 0, extra cycles per fetch beyond the base 1-cycle read; range 0..15.
- NOP_WORD, 32'h0000_0000, word returned when no fetch is active or on an error.

Ports:
- cpu_clk_50M  in  1  system clock; all state changes on the rising edge.
- cpu_rst  in  1  asynchronous, active-high reset.
- ice  in  1  fetch enable from the fetch stage; 1 = request this cycle.
- iaddr  in  32  byte address of the fetch.
- inst  out  32  returned instruction word.
- inst_valid  out  1  `inst` holds the response to an accepted request.
- stallreq  out  1  stall request to the stall controller while a fetch is outstanding.
- addr_err  out  1  misaligned fetch; asserted together with inst_valid.
- load_we  in  1  load-port write strobe.
- load_addr  in  ADDR_W  load-port word index.
- load_data  in  32  load-port write data.

Behaviour:
- Reset (asynchronous, cpu_rst=1):
  - State = IDLE, wait counter = 0, captured address = 0.
  - Outputs: inst=NOP_WORD, inst_valid=0, stallreq=0, addr_err=0.
  - RAM contents are not cleared.
- Indexing:
  - Word index = iaddr[ADDR_W+1:2].
  - Bits above ADDR_W+1 are ignored, so addresses alias modulo the RAM size. This is intended.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - ice=0: stay in IDLE; next cycle inst=NOP_WORD, inst_valid=0.
  - ice=1: capture iaddr and load the counter with WAIT_CYCLES.
    - If WAIT_CYCLES=0, go to RESP.
    - Otherwise go to WAIT.
- WAIT:
  - stallreq=1 combinationally for the whole time the state is WAIT.
  - The counter decrements each cycle; at counter=1, go to RESP.
  - ice and iaddr are ignored in WAIT, because the fetch stage is held by the stall.
- RESP (exactly one cycle):
  - inst = RAM[captured index], inst_valid=1, stallreq=0.
  - If the captured address has bits [1:0] != 0: inst=NOP_WORD and addr_err=1.
  - In the same cycle, if ice=1, accept the new request (back-to-back). Next state is RESP or WAIT by the same rule as IDLE; otherwise go to IDLE.
- Latency: response appears WAIT_CYCLES+1 cycles after the accepting edge.
  - With WAIT_CYCLES=0, throughput is one word per cycle with no stall.
- Read timing: the RAM is read when entering RESP (synchronous read).
  - inst is registered and holds its value until the next RESP or IDLE update. In IDLE it returns to NOP_WORD.
- Load port:
  - load_we writes RAM[load_addr] on the clock edge. It is accepted in any state.
  - A write and a read of the same word in the same edge are read-first: the fetch gets the old data.
- Reset asserted mid-WAIT or mid-RESP: the outstanding fetch is aborted, no response is ever produced, and stallreq drops immediately (asynchronously).
- Counter width is 4 bits; a WAIT_CYCLES value outside 0..15 is a compile-time error.

Optional Feature:
- Macro: IMEM_PREFETCH_EN.
- Enabled: one-entry prefetch buffer (tag, data, valid).
  - After each RESP for address A, while in IDLE or RESP, the block reads word A+4 into the buffer, taking WAIT_CYCLES+1 cycles in the background.
  - A request whose address matches a valid buffer tag skips WAIT and is served in RESP the next cycle from the buffer, with stallreq=0.
  - load_we to the buffered word clears the buffer valid bit.
  - A miss while the prefetch is still in flight cancels the prefetch, then follows the normal path.
- Disabled: no buffer; every fetch pays WAIT_CYCLES.

Test Plan:
- Reset then release, ice=0 for 3 cycles -> inst=0, inst_valid=0, stallreq=0 throughout.
- WAIT_CYCLES=0; load words 0..3 = 32'h11,22,33,44; ice=1 with iaddr 0,4,8,C on consecutive cycles -> inst 11,22,33,44 on consecutive cycles, each one cycle after its request; stallreq never 1.
- WAIT_CYCLES=3; fetch 0x4 -> stallreq=1 for exactly 3 cycles, then inst=32'h22 with inst_valid=1 and stallreq=0.
- Fetch 0x6 -> inst=0, addr_err=1, inst_valid=1 for one cycle; aliasing: with ADDR_W=12, fetch 0x4004 returns the same word as 0x4.
- load_we to word 1 with 32'hDEAD on the same edge a fetch of 0x4 is accepted -> returns old 32'h22; a refetch returns 32'hDEAD. Assert cpu_rst mid-WAIT -> stallreq drops at once and no inst_valid pulse appears.
- With IMEM_PREFETCH_EN, WAIT_CYCLES=3: fetch 0x0, idle 4 cycles, fetch 0x4 -> served with no stallreq; then load to word 2, fetch 0x8 -> full 3-cycle stall.

Source files
------------

// File: rtl/imem_responder.sv
// Instruction-fetch responder: word-addressed RAM with optional wait states and a side load port.
// Optional one-entry prefetch buffer is compiled in when IMEM_PREFETCH_EN is defined.
module imem_responder #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst,
    input  logic              ice,
    input  logic [31:0]       iaddr,
    output logic [31:0]       inst,
    output logic              inst_valid,
    output logic              stallreq,
    output logic              addr_err,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data
);
    if (WAIT_CYCLES > 15) begin : g_bad_wait_cycles
        $error("imem_responder: WAIT_CYCLES must be within 0..15");
    end

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_cnt;
    logic [31:0]       r_addr;
    logic [31:0]       r_inst;
    logic [31:0]       r_mem [2**ADDR_W];

    logic              w_accept;
    logic              w_hit;
    logic [31:0]       w_pf_data;
    logic [31:0]       w_rd_addr;
    logic [ADDR_W-1:0] w_rd_idx;
    logic [31:0]       w_rd_word;
    logic              w_unused;

    // Upper address bits alias onto the RAM; they are captured but never decoded.
    assign w_unused  = ^{r_addr[31:ADDR_W+2]};

    assign w_accept  = ice && (r_state != S_WAIT);
    assign w_rd_addr = w_accept ? iaddr : r_addr;
    assign w_rd_idx  = w_rd_addr[ADDR_W+1:2];
    assign w_rd_word = (w_rd_addr[1:0] != 2'b00)  ? NOP_WORD  :
                       (w_accept && w_hit)        ? w_pf_data :
                                                    r_mem[w_rd_idx];

    always_comb begin
        w_next     = r_state;
        inst       = r_inst;
        inst_valid = 1'b0;
        stallreq   = 1'b0;
        addr_err   = 1'b0;
        case (r_state)
            S_IDLE, S_RESP: begin
                if (ice) begin
                    w_next = ((WAIT_CYCLES == 0) || w_hit) ? S_RESP : S_WAIT;
                end else begin
                    w_next = S_IDLE;
                end
                if (r_state == S_RESP) begin
                    inst_valid = 1'b1;
                    addr_err   = (r_addr[1:0] != 2'b00);
                end
            end
            S_WAIT: begin
                stallreq = 1'b1;
                if (r_cnt == 4'd1) begin
                    w_next = S_RESP;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 32'd0;
            r_inst  <= NOP_WORD;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr <= iaddr;
                r_cnt  <= WAIT_LD;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // The RAM is sampled on the edge that enters RESP, so a same-edge load is read-first.
            if (w_next == S_RESP) begin
                r_inst <= w_rd_word;
            end else if (w_next == S_IDLE) begin
                r_inst <= NOP_WORD;
            end
        end
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (load_we) begin
            r_mem[load_addr] <= load_data;
        end
    end

`ifdef IMEM_PREFETCH_EN
    logic              r_pf_vld;
    logic              r_pf_busy;
    logic [3:0]        r_pf_cnt;
    logic [ADDR_W-1:0] r_pf_tag;
    logic [ADDR_W-1:0] r_pf_idx;
    logic [31:0]       r_pf_data;
    logic              w_miss;

    assign w_hit     = r_pf_vld && (r_pf_tag == iaddr[ADDR_W+1:2]) && (iaddr[1:0] == 2'b00);
    assign w_miss    = w_accept && !w_hit;
    assign w_pf_data = r_pf_data;

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_pf_vld  <= 1'b0;
            r_pf_busy <= 1'b0;
            r_pf_cnt  <= 4'd0;
            r_pf_tag  <= '0;
            r_pf_idx  <= '0;
            r_pf_data <= 32'd0;
        end else begin
            if ((r_state == S_RESP) && (r_addr[1:0] == 2'b00) && !w_miss) begin
                r_pf_busy <= 1'b1;
                r_pf_idx  <= r_addr[ADDR_W+1:2] + 1'b1;
                r_pf_cnt  <= WAIT_LD;
            end else if (r_pf_busy) begin
                if (w_miss || (load_we && (load_addr == r_pf_idx))) begin
                    r_pf_busy <= 1'b0;
                end else if (r_pf_cnt == 4'd0) begin
                    r_pf_busy <= 1'b0;
                    r_pf_vld  <= 1'b1;
                    r_pf_tag  <= r_pf_idx;
                    r_pf_data <= r_mem[r_pf_idx];
                end else begin
                    r_pf_cnt <= r_pf_cnt - 4'd1;
                end
            end
            // A load to the buffered word makes the copy stale.
            if (load_we && (load_addr == r_pf_tag)) begin
                r_pf_vld <= 1'b0;
            end
        end
    end
`else
    assign w_hit     = 1'b0;
    assign w_pf_data = NOP_WORD;
`endif

endmodule
